// File: rtl/ysyx_22051013_csr_trap.sv
// rtl/ysyx_22051013_csr_trap.sv - machine-mode CSR file with ecall/interrupt trap entry and mret
// Optional mcycle/minstret counters are built when YSYX_22051013_CSR_COUNTERS_EN is defined.

module ysyx_22051013_csr_trap #(
    parameter int XLEN    = 64,
    parameter int HART_ID = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            ecall,
    input  logic            mret,
    input  logic            instr_retire,
    input  logic [XLEN-1:0] pc,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] mret_pc,
    output logic            illegal_csr
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [XLEN-1:0] CAUSE_MSB = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALIGN4    = {{(XLEN-2){1'b1}}, 2'b00};

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [1:0]      r_mstatus_mpp;
    logic            r_mie_mtie;
    logic            r_mie_meie;
    logic            r_mip_mtip;
    logic            r_mip_meip;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mie;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_vec_off;
    logic [3:0]      w_code;
    logic            w_impl;
    logic            w_ro;
    logic            w_wants_write;
    logic            w_we;
    logic            w_ext_pend;
    logic            w_tmr_pend;
    logic            w_irq_take;
    logic            w_trap;

`ifdef YSYX_22051013_CSR_COUNTERS_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic [63:0] w_mcycle_nx;
    logic [63:0] w_minstret_nx;
`endif

    always_comb begin
        w_mstatus            = '0;
        w_mstatus[3]         = r_mstatus_mie;
        w_mstatus[7]         = r_mstatus_mpie;
        w_mstatus[12:11]     = r_mstatus_mpp;
        w_mie                = '0;
        w_mie[7]             = r_mie_mtie;
        w_mie[11]            = r_mie_meie;
        w_mip                = '0;
        w_mip[7]             = r_mip_mtip;
        w_mip[11]            = r_mip_meip;
    end

    always_comb begin
        w_old  = '0;
        w_impl = 1'b1;
        w_ro   = 1'b0;
        case (csr_addr)
            A_MSTATUS:  w_old = w_mstatus;
            A_MIE:      w_old = w_mie;
            A_MTVEC:    w_old = r_mtvec;
            A_MSCRATCH: w_old = r_mscratch;
            A_MEPC:     w_old = r_mepc;
            A_MCAUSE:   w_old = r_mcause;
            A_MIP: begin
                w_old = w_mip;
                w_ro  = 1'b1;
            end
            A_MHARTID: begin
                w_old = XLEN'(HART_ID);
                w_ro  = 1'b1;
            end
`ifdef YSYX_22051013_CSR_COUNTERS_EN
            A_MCYCLE:   w_old = r_mcycle[XLEN-1:0];
            A_MINSTRET: w_old = r_minstret[XLEN-1:0];
`endif
            default:    w_impl = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            OP_SET:   w_new = w_old | csr_wdata;
            OP_CLEAR: w_new = w_old & ~csr_wdata;
            default:  w_new = csr_wdata;
        endcase
    end

    // set/clear with a zero operand is a pure read, even on read-only CSRs
    assign w_wants_write = (csr_op == OP_WRITE) | (csr_op[1] & (|csr_wdata));
    assign illegal_csr   = ~rst & (csr_op != OP_NONE) & (~w_impl | (w_ro & w_wants_write));
    assign w_we          = ~rst & w_wants_write & w_impl & ~w_ro;
    assign csr_rdata     = ((csr_op != OP_NONE) && w_impl) ? w_old : '0;

    assign w_ext_pend = r_mip_meip & r_mie_meie;
    assign w_tmr_pend = r_mip_mtip & r_mie_mtie;
    assign w_irq_take = r_mstatus_mie & instr_retire & (w_ext_pend | w_tmr_pend);
    assign w_trap     = ~rst & (ecall | w_irq_take);
    assign trap_valid = w_trap;

    assign w_code    = (ecall | w_ext_pend) ? 4'd11 : 4'd7;
    assign w_cause   = {{(XLEN-4){1'b0}}, w_code} | (ecall ? '0 : CAUSE_MSB);
    assign w_vec_off = (~ecall & (r_mtvec[1:0] == 2'b01)) ? {{(XLEN-6){1'b0}}, w_code, 2'b00} : '0;
    assign trap_pc   = {r_mtvec[XLEN-1:2], 2'b00} + w_vec_off;
    assign mret_pc   = r_mepc;

    // Later assignments win: CSR write, then mret, then trap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mstatus_mpp  <= 2'b00;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mip_mtip     <= 1'b0;
            r_mip_meip     <= 1'b0;
            r_mtvec        <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
        end else begin
            r_mip_mtip <= irq_timer;
            r_mip_meip <= irq_ext;
            if (w_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        r_mstatus_mie  <= w_new[3];
                        r_mstatus_mpie <= w_new[7];
                        r_mstatus_mpp  <= w_new[12:11];
                    end
                    A_MIE: begin
                        r_mie_mtie <= w_new[7];
                        r_mie_meie <= w_new[11];
                    end
                    A_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2], 1'b0, (w_new[1:0] == 2'b01)};
                    A_MSCRATCH: r_mscratch <= w_new;
                    A_MEPC:     r_mepc     <= w_new & ALIGN4;
                    A_MCAUSE:   r_mcause   <= w_new;
                    default: ;
                endcase
            end
            if (mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
                r_mstatus_mpp  <= 2'b00;
            end
            if (w_trap) begin
                r_mepc         <= pc & ALIGN4;
                r_mcause       <= w_cause;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mstatus_mpp  <= 2'b11;
            end
        end
    end

`ifdef YSYX_22051013_CSR_COUNTERS_EN
    always_comb begin
        w_mcycle_nx   = r_mcycle + 64'd1;
        w_minstret_nx = r_minstret + {63'd0, instr_retire};
        if (w_we && csr_addr == A_MCYCLE) begin
            w_mcycle_nx              = r_mcycle;
            w_mcycle_nx[XLEN-1:0]    = w_new;
        end
        if (w_we && csr_addr == A_MINSTRET) begin
            w_minstret_nx            = r_minstret;
            w_minstret_nx[XLEN-1:0]  = w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            r_mcycle   <= w_mcycle_nx;
            r_minstret <= w_minstret_nx;
        end
    end
`endif

endmodule

// File: doc/ysyx_22051013_csr_trap.md
YSYX_22051013_CSR_TRAP -- requirements
Module: ysyx_22051013_csr_trap

Interface
REQ-001 SHALL have parameter XLEN, default 64, the CSR width; legal values are 32 and 64.
REQ-002 SHALL have parameter HART_ID, default 0, the constant returned by a read of mhartid.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports csr_addr (in, 12, CSR address), csr_op (in, 2: 00 none, 01 write, 10 set, 11 clear), csr_wdata (in, XLEN, operand) and csr_rdata (out, XLEN, read data).
REQ-006 SHALL have ports ecall, mret and instr_retire (in, 1 each, single-cycle pulses) and pc (in, XLEN, PC of the current instruction).
REQ-007 SHALL have ports irq_timer and irq_ext, in, 1 each, level-sensitive interrupt requests.
REQ-008 SHALL have ports trap_valid (out, 1, redirect to trap), trap_pc (out, XLEN), mret_pc (out, XLEN, current mepc) and illegal_csr (out, 1).

Function
REQ-009 SHALL implement mstatus 0x300 (only MIE[3], MPIE[7] and MPP[12:11] are stored; other bits read 0), mie 0x304 (MTIE[7], MEIE[11]), mtvec 0x305 (BASE[XLEN-1:2], MODE[1:0] with 0=direct, 1=vectored, 2/3 written as 0), mscratch 0x340, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mip 0x344 (read-only), and mhartid 0xF14 (read-only).
REQ-010 SHALL drive csr_rdata combinationally from the old value at csr_addr, and drive 0 when csr_op=00 or the address is unimplemented.
REQ-011 SHALL update the CSR at the next rising edge as follows: write sets new=wdata, set sets new=old|wdata, clear sets new=old&~wdata.
REQ-012 SHALL, for set or clear with wdata=0, perform no write side effect.
REQ-013 SHALL assert illegal_csr combinationally when csr_op!=00 and the address is unimplemented, or when csr_op is write, or set/clear with wdata!=0, to mip or mhartid; no state SHALL change.
REQ-014 SHALL register irq_timer and irq_ext into mip.MTIP[7] and mip.MEIP[11] every cycle, giving 1 cycle of latency.
REQ-015 SHALL set irq_take = mstatus.MIE & instr_retire & ((mip.MEIP&mie.MEIE)|(mip.MTIP&mie.MTIE)).
REQ-016 SHALL give the external interrupt priority over the timer interrupt.
REQ-017 SHALL take a trap when ecall or irq_take is true; ecall has priority over irq_take in the same cycle.
REQ-018 SHALL drive trap_valid combinationally in the trap cycle.
REQ-019 SHALL use these mcause values: ecall = 11; timer = MSB|7; external = MSB|11, where MSB is bit XLEN-1.
REQ-020 SHALL drive trap_pc = BASE<<2 for an exception or in direct mode, and BASE<<2 + 4*code for an interrupt in vectored mode.
REQ-021 SHALL, at the edge ending a trap cycle, load mepc<=pc and mcause<=cause, and set MPIE<=MIE, MIE<=0, MPP<=2'b11.
REQ-022 SHALL, on mret without a trap, set MIE<=MPIE, MPIE<=1 and MPP<=2'b00.
REQ-023 SHALL drive mret_pc = mepc at all times.
REQ-024 SHALL apply this priority per edge: reset > trap > mret > CSR instruction write; the lower-priority update to the same fields is dropped.
REQ-025 SHALL let a CSR write to a field not touched by the trap or mret complete normally in that cycle.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, clear mstatus, mie, mtvec, mscratch, mepc, mcause, mip and the counters to 0.
REQ-027 SHALL keep trap_valid=0 and illegal_csr=0 while rst=1.
REQ-028 SHALL have reset override any trap, mret or write in the same cycle.

Configuration
REQ-029 SHALL, with YSYX_22051013_CSR_COUNTERS_EN defined, implement mcycle 0xB00 and minstret 0xB02, each 64 bits.
REQ-030 SHALL increment mcycle every cycle and increment minstret on instr_retire, both wrapping 2^64-1 -> 0.
REQ-031 SHALL let a CSR write to mcycle or minstret replace that cycle's increment.
REQ-032 SHALL, without YSYX_22051013_CSR_COUNTERS_EN, synthesise no counter logic and treat 0xB00 and 0xB02 as unimplemented, so illegal_csr=1.

Verification
REQ-033 SHALL cover: write mtvec=0x8000_0100, then ecall with pc=0x8000_0040 -> trap_valid=1, trap_pc=0x8000_0100, then mepc=0x8000_0040, mcause=11, MIE=0, MPP=3.
REQ-034 SHALL cover: mtvec=0x8000_0101, MIE=1, MTIE=1, irq_timer=1, then instr_retire -> trap_pc=0x8000_011C, mcause=0x8000_0000_0000_0007.
REQ-035 SHALL cover: irq_timer=1 and irq_ext=1 with both enabled -> mcause=MSB|11; with mstatus.MIE=0 -> no trap.
REQ-036 SHALL cover: set mscratch with 0xF0 over 0x0F -> 0xFF; clear with 0x0F -> 0xF0; write to mhartid -> illegal_csr=1 and the value stays HART_ID.
REQ-037 SHALL cover: mret with MPIE=1 -> MIE=1, MPIE=1, MPP=0, mret_pc=mepc; ecall and mstatus write in the same cycle -> trap result wins.
REQ-038 SHALL cover: with COUNTERS_EN, mcycle written to 0xFFFF_FFFF_FFFF_FFFF -> reads 0 two cycles later; rst mid-trap -> all CSRs 0.
